// File: rtl/addsub_result_stage.sv
// rtl/addsub_result_stage.sv - registered result/flag stage with a 2-entry skid buffer behind the add/sub unit
// Optional sticky overflow flag (ovf_clear/sticky_ovf ports) is built when STICKY_OVF_EN is defined.
module addsub_result_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  input  logic             in_control,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
`ifdef STICKY_OVF_EN
  ,
  input  logic             ovf_clear,
  output logic             sticky_ovf
`endif
);

  // Beat layout: {ovf, neg, zero, carry, result}
  localparam int BW    = WIDTH + 4;
  localparam int B_CRY = WIDTH;
  localparam int B_ZER = WIDTH + 1;
  localparam int B_NEG = WIDTH + 2;
  localparam int B_OVF = WIDTH + 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   main_q, main_d;
  logic [BW-1:0]   skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic [BW-1:0]   in_beat;
  logic            accept;
  logic            consume;
  logic            res_msb;
  logic            in_ovf;
  logic            in_carry;

  always_comb begin
    res_msb  = in_result[WIDTH-1];
    in_carry = in_control ? ~in_cout : in_cout;
    // Subtract inverts b, so the "operands share a sign" test flips.
    if (in_control) begin
      in_ovf = (in_a_msb != in_b_msb) && (res_msb != in_a_msb);
    end else begin
      in_ovf = (in_a_msb == in_b_msb) && (res_msb != in_a_msb);
    end
    in_beat = {in_ovf, res_msb, (in_result == '0), in_carry, in_result};
  end

  assign accept    = in_valid && in_ready_q;
  assign consume   = (state_q != ST_EMPTY) && out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_beat;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !consume) begin
          skid_d  = in_beat;
          state_d = ST_FULL;
        end else if (consume && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && consume) begin
          main_d  = in_beat;
        end
      end
      ST_FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready: look ahead at the next occupancy.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_result = main_q[WIDTH-1:0];
  assign out_carry  = main_q[B_CRY];
  assign out_zero   = main_q[B_ZER];
  assign out_neg    = main_q[B_NEG];
  assign out_ovf    = main_q[B_OVF];

`ifdef STICKY_OVF_EN
  logic sticky_ovf_q, sticky_ovf_d;

  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    if (ovf_clear) begin
      sticky_ovf_d = 1'b0;
    end else if (consume && main_q[B_OVF]) begin
      sticky_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
`endif

endmodule

// File: tb/tb_addsub_result_stage.sv
// tb/tb_addsub_result_stage.sv - scoreboard bench for addsub_result_stage (STICKY_OVF_EN optional)
module tb_addsub_result_stage;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_result;
  logic         in_cout;
  logic         in_control;
  logic         in_a_msb;
  logic         in_b_msb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;
  logic         out_neg;
  logic         out_ovf;
`ifdef STICKY_OVF_EN
  logic         ovf_clear;
  logic         sticky_ovf;
  logic         sticky_m;
`endif

  addsub_result_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_cout(in_cout), .in_control(in_control),
    .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
    .out_neg(out_neg), .out_ovf(out_ovf)
`ifdef STICKY_OVF_EN
    , .ovf_clear(ovf_clear), .sticky_ovf(sticky_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  logic [W+3:0] sb[$];
  int cons_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {in_cout, ovf, neg, zero, carry, result}.
  function automatic logic [W+4:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ctrl, input logic cin);
    int ua, ub, sa, sb_, u, s, lim;
    logic [W-1:0] r;
    logic carry, cout, ovf;
    lim = 1 << W;
    ua = a; ub = b;
    sa = a[W-1] ? ua - lim : ua;
    sb_ = b[W-1] ? ub - lim : ub;
    if (!ctrl) begin
      u = ua + ub + cin; s = sa + sb_ + cin;
      carry = (u >= lim); cout = carry;
    end else begin
      u = ua - ub; s = sa - sb_;
      carry = (ua < ub); cout = !carry;
    end
    r = W'(u & (lim - 1));
    ovf = (s > lim / 2 - 1) || (s < -(lim / 2));
    return {cout, ovf, r[W-1], (r == 0), carry, r};
  endfunction

  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ctrl, input logic cin);
    logic [W+4:0] m;
    m = model(a, b, ctrl, cin);
    in_result  = m[W-1:0];
    in_cout    = m[W+4];
    in_control = ctrl;
    in_a_msb   = a[W-1];
    in_b_msb   = b[W-1];
    in_valid   = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge with in_valid still 1.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ctrl, input logic cin);
    logic [W+4:0] m;
    bit done;
    done = 0;
    m = model(a, b, ctrl, cin);
    set_in(a, b, ctrl, cin);
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(m[W+3:0]);
        n_acc++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 64 cycles");
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: pop on every consumed beat, check stall stability and the sticky model.
  initial begin : monitor
    bit stall;
    logic [W+3:0] held, act, exp;
    stall = 0;
    held = '0;
`ifdef STICKY_OVF_EN
    sticky_m = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
`ifdef STICKY_OVF_EN
        sticky_m = 1'b0;
`endif
        continue;
      end
      act = {out_ovf, out_neg, out_zero, out_carry, out_result};
`ifdef STICKY_OVF_EN
      chk("sticky_ovf", sticky_ovf, sticky_m);
      if (ovf_clear) sticky_m = 1'b0;
      else if (out_valid && out_ready && out_ovf) sticky_m = 1'b1;
`endif
      if (out_valid) begin
        if (stall) chk("stall_stable", act, held);
        if (out_ready) begin
          stall = 0;
          cons_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h expected no output", act);
          end else begin
            exp = sb.pop_front();
            chk("beat", act, exp);
          end
        end else begin
          stall = 1;
          held = act;
        end
      end else begin
        stall = 0;
      end
    end
  end

  initial begin : stim
    int n0, t0;
    bit rdone;
    rst_n = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0; in_result = '0; in_cout = 0; in_control = 0; in_a_msb = 0; in_b_msb = 0;
`ifdef STICKY_OVF_EN
    ovf_clear = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fields", {out_ovf, out_neg, out_zero, out_carry, out_result}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Directed add with signed overflow, then subtract to zero.
    out_ready = 1'b1;
    drive(4'b0111, 4'b0001, 1'b0, 1'b0);
    chk("t1_latency_valid", out_valid, 1);
    chk("t1_result", out_result, 4'b1000);
    chk("t1_flags", {out_carry, out_neg, out_ovf, out_zero}, 4'b0110);
    drive(4'b0011, 4'b0011, 1'b1, 1'b0);
    chk("t2_result", out_result, 4'b0000);
    chk("t2_flags", {out_carry, out_zero, out_ovf}, 3'b010);
    idle();
    @(posedge clk); #1;

    // Back-pressure: two beats fill the buffer, third waits for a consume.
    out_ready = 1'b0;
    n0 = n_acc;
    drive(4'd5, 4'd6, 1'b0, 1'b1);
    drive(4'd2, 4'd9, 1'b1, 1'b0);
    set_in(4'd15, 4'd15, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("t3_in_ready_low", in_ready, 0);
      chk("t3_head_result", out_result, 4'd12);
    end
    chk("t3_accepted", n_acc - n0, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(4'd15, 4'd15, 1'b0, 1'b1);
    idle();
    repeat (4) @(posedge clk); #1;

    // Throughput: 8 back-to-back beats.
    n0 = cons_cyc.size();
    t0 = cyc;
    for (int i = 0; i < 8; i++) drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    chk("t4_drive_cycles", cyc - t0, 8);
    idle();
    repeat (3) @(posedge clk); #1;
    chk("t4_out_count", cons_cyc.size() - n0, 8);
    if (cons_cyc.size() - n0 == 8) chk("t4_out_span", cons_cyc[n0 + 7] - cons_cyc[n0], 7);

    // Reset while full.
    out_ready = 1'b0;
    drive(4'd1, 4'd2, 1'b0, 1'b0);
    drive(4'd3, 4'd4, 1'b1, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

`ifdef STICKY_OVF_EN
    // Sticky: set by an ovf consume, held through clean beats, clear wins.
    drive(4'b0111, 4'b0001, 1'b0, 1'b0);
    drive(4'd1, 4'd1, 1'b0, 1'b0);
    drive(4'd2, 4'd1, 1'b1, 1'b0);
    idle();
    repeat (3) @(posedge clk); #1;
    chk("t6_sticky_held", sticky_ovf, 1);
    out_ready = 1'b0;
    drive(4'b1000, 4'b0001, 1'b1, 1'b0);
    idle();
    ovf_clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    chk("t6_clear_wins", sticky_ovf, 0);
    repeat (2) @(posedge clk); #1;
`endif

    // Randomized traffic with random back-pressure.
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
          if ($urandom_range(3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(2) != 0);
`ifdef STICKY_OVF_EN
          ovf_clear = ($urandom_range(9) == 0);
`endif
        end
      end
    join
    out_ready = 1'b1;
`ifdef STICKY_OVF_EN
    ovf_clear = 1'b0;
`endif
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
    @(negedge clk);
    chk("final_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
